// File: rtl/sram_bridge_pkg.sv
// ============================================================================
// Module   : sram_bridge_pkg
// Brief    : Shared defines for the core-to-SRAM bridge (bus width, strobes,
//            FSM encodings).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_bridge_pkg;

  localparam int RegBus          = 32;
  localparam int SramWaitDefault = 1;

  localparam logic SramStrobeOn  = 1'b0;
  localparam logic SramStrobeOff = 1'b1;

  typedef enum logic [2:0] {
    SRAM_IDLE     = 3'd0,
    SRAM_RD       = 3'd1,
    SRAM_WR_SETUP = 3'd2,
    SRAM_WR_PULSE = 3'd3,
    SRAM_WR_HOLD  = 3'd4
  } sram_state_e;

endpackage

`default_nettype wire

// File: rtl/sram_bridge.sv
// ============================================================================
// Module   : sram_bridge
// Brief    : Serialises instruction fetches and data accesses onto one
//            asynchronous 32-bit SRAM and stalls the core until both finish.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_bridge
  import sram_bridge_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = SramWaitDefault
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              rom_ce_i,
  input  logic [RegBus-1:0] rom_addr_i,
  output logic [RegBus-1:0] rom_data_o,

  input  logic              ram_ce_i,
  input  logic              ram_we_i,
  input  logic [3:0]        ram_sel_i,
  input  logic [RegBus-1:0] ram_addr_i,
  input  logic [RegBus-1:0] ram_data_i,
  output logic [RegBus-1:0] ram_data_o,

  output logic              stallreq_o,

  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [RegBus-1:0] sram_data_o,
  output logic              sram_data_oe_o,
  input  logic [RegBus-1:0] sram_data_i,
  output logic [3:0]        sram_be_n_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o
);

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

  sram_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              is_fetch_q, is_fetch_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic [RegBus-1:0] rom_data_q, rom_data_d;
  logic [RegBus-1:0] ram_data_q, ram_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RegBus-1:0] wdata_q, wdata_d;
  logic [3:0]        be_n_q, be_n_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              data_oe_q, data_oe_d;

  logic              unused_addr_bits;
  assign unused_addr_bits = ^{rom_addr_i[RegBus-1:ADDR_W+2], rom_addr_i[1:0],
                              ram_addr_i[RegBus-1:ADDR_W+2], ram_addr_i[1:0]};

  assign stallreq_o = (ram_ce_i & ~d_done_q) | (rom_ce_i & ~i_done_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_fetch_d = is_fetch_q;
    i_done_d   = i_done_q;
    d_done_d   = d_done_q;
    rom_data_d = rom_data_q;
    ram_data_d = ram_data_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_n_d     = be_n_q;
    ce_n_d     = ce_n_q;
    oe_n_d     = oe_n_q;
    we_n_d     = we_n_q;
    data_oe_d  = data_oe_q;

    // Strobe registers are loaded with the values of the state being entered,
    // so every SRAM pin comes straight from a flop.
    unique case (state_q)
      SRAM_IDLE: begin
        if (!stallreq_o) begin
          i_done_d = 1'b0;
          d_done_d = 1'b0;
        end else if (ram_ce_i && !d_done_q) begin
          is_fetch_d = 1'b0;
          addr_d     = ram_addr_i[ADDR_W+1:2];
          ce_n_d     = SramStrobeOn;
          if (ram_we_i) begin
            state_d   = SRAM_WR_SETUP;
            wdata_d   = ram_data_i;
            be_n_d    = ~ram_sel_i;
            data_oe_d = 1'b1;
          end else begin
            state_d = SRAM_RD;
            cnt_d   = WaitLoad;
            oe_n_d  = SramStrobeOn;
            be_n_d  = 4'h0;
          end
        end else if (rom_ce_i && !i_done_q) begin
          state_d    = SRAM_RD;
          cnt_d      = WaitLoad;
          is_fetch_d = 1'b1;
          addr_d     = rom_addr_i[ADDR_W+1:2];
          ce_n_d     = SramStrobeOn;
          oe_n_d     = SramStrobeOn;
          be_n_d     = 4'h0;
        end
      end

      SRAM_RD: begin
        if (cnt_q == 4'd0) begin
          if (is_fetch_q) begin
            rom_data_d = sram_data_i;
            i_done_d   = 1'b1;
          end else begin
            ram_data_d = sram_data_i;
            d_done_d   = 1'b1;
          end
          state_d = SRAM_IDLE;
          ce_n_d  = SramStrobeOff;
          oe_n_d  = SramStrobeOff;
          be_n_d  = 4'hF;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      SRAM_WR_SETUP: begin
        state_d = SRAM_WR_PULSE;
        cnt_d   = WaitLoad;
        we_n_d  = SramStrobeOn;
      end

      SRAM_WR_PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = SRAM_WR_HOLD;
          we_n_d  = SramStrobeOff;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      SRAM_WR_HOLD: begin
        state_d   = SRAM_IDLE;
        d_done_d  = 1'b1;
        ce_n_d    = SramStrobeOff;
        be_n_d    = 4'hF;
        data_oe_d = 1'b0;
      end

      default: begin
        state_d = SRAM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SRAM_IDLE;
      cnt_q      <= 4'd0;
      is_fetch_q <= 1'b0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      rom_data_q <= '0;
      ram_data_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_n_q     <= 4'hF;
      ce_n_q     <= SramStrobeOff;
      oe_n_q     <= SramStrobeOff;
      we_n_q     <= SramStrobeOff;
      data_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_fetch_q <= is_fetch_d;
      i_done_q   <= i_done_d;
      d_done_q   <= d_done_d;
      rom_data_q <= rom_data_d;
      ram_data_q <= ram_data_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_n_q     <= be_n_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      data_oe_q  <= data_oe_d;
    end
  end

  assign rom_data_o     = rom_data_q;
  assign ram_data_o     = ram_data_q;
  assign sram_addr_o    = addr_q;
  assign sram_data_o    = wdata_q;
  assign sram_data_oe_o = data_oe_q;
  assign sram_be_n_o    = be_n_q;
  assign sram_ce_n_o    = ce_n_q;
  assign sram_oe_n_o    = oe_n_q;
  assign sram_we_n_o    = we_n_q;

endmodule

`default_nettype wire

// File: doc/sram_bridge.md
Name: sram_bridge

Overview:
- Sits directly downstream of the GenshinMIPS core, at the top level.
- Consumes the core's instruction-port (rom_*) and data-port (ram_*) requests and serialises them onto one external asynchronous 32-bit SRAM with multi-cycle timing.
- Returns read data to the core and raises a stall request until every access requested in the current core cycle has completed. This stall request is ctrl's new input stallreq_from_mem, which freezes the whole pipeline.

Parameters:
- ADDR_W, 20, SRAM word-address width (1M words).
- WAIT_CYCLES, 1, extra cycles the SRAM strobe is held beyond the minimum of 1 (range 0..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rom_ce_i  in  1  instruction fetch request
- rom_addr_i  in  32  fetch byte address
- rom_data_o  out  32  fetched instruction
- ram_ce_i  in  1  data access request
- ram_we_i  in  1  1=write, 0=read
- ram_sel_i  in  4  byte enables, bit0 = bits[7:0]
- ram_addr_i  in  32  data byte address
- ram_data_i  in  32  store data from core
- ram_data_o  out  32  load data to core
- stallreq_o  out  1  pipeline stall request to ctrl
- sram_addr_o  out  ADDR_W  SRAM word address
- sram_data_o  out  32  SRAM write data
- sram_data_oe_o  out  1  1 = top-level tristate drives the SRAM bus
- sram_data_i  in  32  SRAM read data
- sram_be_n_o  out  4  byte enables, active-low
- sram_ce_n_o  out  1  chip enable, active-low
- sram_oe_n_o  out  1  output enable, active-low
- sram_we_n_o  out  1  write enable, active-low

Behaviour:
- Reset (rst=0, asynchronous, effective mid-access):
  - FSM goes to IDLE and the counter clears; i_done and d_done clear.
  - rom_data_o and ram_data_o = 0.
  - sram_ce_n_o, sram_oe_n_o and sram_we_n_o = 1; sram_be_n_o = 4'hF; sram_data_oe_o = 0.
  - sram_addr_o and sram_data_o = 0.
  - An interrupted write is abandoned; the SRAM content at that word is undefined.
- Stall rule: stallreq_o = (ram_ce_i & ~d_done) | (rom_ce_i & ~i_done). It is combinational from registered flags, so it is 1 in the same cycle a new request appears.
- Core inputs are held stable while stallreq_o=1, because the core is frozen by ctrl.
- On the first rising edge with stallreq_o=0, i_done and d_done clear: the core advances and its next requests are new.
- Priority: the data access is served before the instruction fetch whenever both are pending, since the data access belongs to the older instruction.
- Address mapping: sram_addr_o = addr[ADDR_W+1:2]. Address bits above ADDR_W+1 and bits [1:0] are ignored, so the address wraps modulo 4*2^ADDR_W bytes.
- All SRAM outputs are registered, so no combinational path runs from core inputs to the SRAM pins.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE:
  - If ram_ce_i & ~d_done: go to WR_SETUP if ram_we_i, else RD.
  - Else if rom_ce_i & ~i_done: go to RD, tagged as a fetch.
  - The address, data, sel and tag are latched on this edge.
- RD:
  - Drive ce_n=0, oe_n=0, be_n=0000, data_oe=0 for exactly WAIT_CYCLES+1 cycles.
  - On the final edge, capture sram_data_i into ram_data_o (if data) or rom_data_o (if fetch) and set the matching done flag; go to IDLE with strobes deasserted.
- WR_SETUP: 1 cycle; ce_n=0, we_n=1, data_oe=1, sram_data_o = store data, be_n = ~ram_sel_i.
- WR_PULSE: we_n=0 for WAIT_CYCLES+1 cycles, with address, data and be held.
- WR_HOLD: 1 cycle; we_n=1, data still driven, ce_n=0. On exit, set d_done and go to IDLE.
- ram_data_o is unchanged by writes.
- Latency, measured as cycles with stallreq_o=1:
  - Fetch only: WAIT_CYCLES+2.
  - Load only: WAIT_CYCLES+2.
  - Store only: WAIT_CYCLES+4.
  - Both ports: the data latency plus the fetch latency.
- ram_ce_i=0 and rom_ce_i=0: stay in IDLE with stallreq_o=0.
- A read after a write always passes through IDLE, so oe_n is never 0 in the same cycle as data_oe=1: no bus contention.
- Done data is held in rom_data_o/ram_data_o until the next capture, so it is stable during the non-stall cycle the core samples.

Decomposition:
- Add to the shared defines file:
  - SRAM state encodings.
  - SramWaitDefault.
  - Active-low strobe constants (SramStrobeOn=1'b0, SramStrobeOff=1'b1).
- Reuse the existing RegBus.
- No sub-module: the FSM and the wait counter (4 bits, loaded with WAIT_CYCLES) live in one module.
- The tristate buffer stays in the board-level top, not in this module.

Test Plan (WAIT_CYCLES=1 unless stated):
- Fetch only: rom_addr_i=0x0000_0010, SRAM word 4=0x2401_0005 -> stallreq_o=1 for 3 cycles, then rom_data_o=0x2401_0005 with stall=0; sram_addr_o=4 during RD.
- Store with byte select: ram_we_i=1, ram_sel_i=4'b0010, ram_addr_i=0x0000_0104, ram_data_i=0x0000_AB00 -> sram_addr_o=0x41, be_n=1101, we_n low 2 cycles, stall 5 cycles; a later load of 0x104 returns only byte1 changed (0xAB).
- Simultaneous load and fetch: load 0x200 (word=0xDEAD_BEEF), fetch 0x0 (word=0x3C01_8000) -> the data read is served first, stall 6 cycles; both outputs are correct on the release cycle.
- Store immediately followed by a load to the same address -> the load returns the stored value; data_oe=0 for the whole RD window, never overlapping oe_n=0.
- Reset asserted during WR_PULSE -> we_n, ce_n and oe_n go to 1 asynchronously, stallreq_o=0 while neither ram_ce_i nor rom_ce_i is asserted, FSM in IDLE; a new fetch after release works normally.
- WAIT_CYCLES=0 and address wrap: fetch 0x0040_0008 with ADDR_W=20 -> sram_addr_o=2, stall 2 cycles.
